// File: rtl/elevator_dispatch_scheduler.sv
// SCAN request scheduler and motion/door sequencer for a 4-floor elevator car.
// Optional idle homing to floor 0 is enabled by defining SCHED_IDLE_HOME_EN.
module elevator_dispatch_scheduler #(
    parameter int unsigned MOVE_TICKS = 4,
    parameter int unsigned DOOR_TICKS = 3,
    parameter int unsigned IDLE_TICKS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] hall_up,
    input  logic [2:0] hall_down,
    input  logic [3:0] car_call,
    output logic [1:0] actualFloor,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic       dir_up,
    output logic [3:0] pending,
    output logic       busy
);

    localparam int unsigned MW = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam int unsigned DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

    typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

    state_e          state_q, state_d;
    logic [1:0]      floor_q, floor_d;
    logic            dir_q, dir_d;
    logic [3:0]      pending_q, pending_d;
    logic [MW-1:0]   move_cnt_q, move_cnt_d;
    logic [DW-1:0]   door_cnt_q, door_cnt_d;

    logic [3:0]      req;
    logic [3:0]      req_mask;
    logic [3:0]      clr;
    logic [3:0]      home_set;
    logic [1:0]      next_floor;

    // True when any request bit lies strictly beyond fl in the given direction.
    function automatic logic any_ahead(input logic [3:0] p, input logic [1:0] fl,
                                       input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (up ? (i > int'(fl)) : (i < int'(fl))) r = r | p[i];
        end
        return r;
    endfunction

    assign req = car_call | {1'b0, hall_up} | {hall_down, 1'b0};

    always_comb begin
        next_floor = floor_q;
        if (dir_q && floor_q != 2'd3) begin
            next_floor = floor_q + 2'd1;
        end else if (!dir_q && floor_q != 2'd0) begin
            next_floor = floor_q - 2'd1;
        end
    end

`ifdef SCHED_IDLE_HOME_EN
    localparam int unsigned IW = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS) : 1;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = '0;
        home_set   = 4'b0000;
        if (state_q == StIdle && pending_q == 4'b0000 && floor_q != 2'd0) begin
            if (idle_cnt_q == IW'(IDLE_TICKS - 1)) begin
                home_set = 4'b0001;
            end else begin
                idle_cnt_d = idle_cnt_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_idle_ticks;
    assign unused_idle_ticks = ^IDLE_TICKS;
    assign home_set = 4'b0000;
`endif

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        move_cnt_d = move_cnt_q;
        door_cnt_d = door_cnt_q;
        clr        = 4'b0000;
        req_mask   = req;

        unique case (state_q)
            StIdle: begin
                if (pending_q[floor_q]) begin
                    state_d        = StDoor;
                    door_cnt_d     = '0;
                    clr[floor_q]   = 1'b1;
                end else if (any_ahead(pending_q, floor_q, dir_q)) begin
                    state_d    = StMove;
                    move_cnt_d = '0;
                end else if (any_ahead(pending_q, floor_q, !dir_q)) begin
                    state_d    = StMove;
                    dir_d      = !dir_q;
                    move_cnt_d = '0;
                end
            end
            StMove: begin
                if (move_cnt_q == MW'(MOVE_TICKS - 1)) begin
                    floor_d    = next_floor;
                    move_cnt_d = '0;
                    if (pending_q[next_floor]) begin
                        state_d         = StDoor;
                        door_cnt_d      = '0;
                        clr[next_floor] = 1'b1;
                    end else if (!any_ahead(pending_q, next_floor, dir_q)) begin
                        state_d = StIdle;
                    end
                end else begin
                    move_cnt_d = move_cnt_q + MW'(1);
                end
            end
            StDoor: begin
                // A call for the served floor keeps the door open instead of queueing.
                if (req[floor_q]) begin
                    door_cnt_d        = '0;
                    req_mask[floor_q] = 1'b0;
                end else if (door_cnt_q == DW'(DOOR_TICKS - 1)) begin
                    state_d    = StIdle;
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + DW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        pending_d = (pending_q | req_mask | home_set) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            floor_q    <= 2'd0;
            dir_q      <= 1'b1;
            pending_q  <= 4'b0000;
            move_cnt_q <= '0;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            pending_q  <= pending_d;
            move_cnt_q <= move_cnt_d;
            door_cnt_q <= door_cnt_d;
        end
    end

    assign actualFloor = floor_q;
    assign motor_up    = (state_q == StMove) && dir_q;
    assign motor_down  = (state_q == StMove) && !dir_q;
    assign door_open   = (state_q == StDoor);
    assign dir_up      = dir_q;
    assign pending     = pending_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_elevator_dispatch_scheduler.sv
// Randomized scoreboard bench for elevator_dispatch_scheduler against a countdown-based model.
module tb_elevator_dispatch_scheduler;

    localparam int MOVE_T = 4;
    localparam int DOOR_T = 3;
    localparam int PH_IDLE = 0;
    localparam int PH_MOVE = 1;
    localparam int PH_DOOR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] hall_up = 3'b000;
    logic [2:0] hall_down = 3'b000;
    logic [3:0] car_call = 4'b0000;
    logic [1:0] actualFloor;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic       dir_up;
    logic [3:0] pending;
    logic       busy;

    elevator_dispatch_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .hall_up    (hall_up),
        .hall_down  (hall_down),
        .car_call   (car_call),
        .actualFloor(actualFloor),
        .motor_up   (motor_up),
        .motor_down (motor_down),
        .door_open  (door_open),
        .dir_up     (dir_up),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: floor as integer, cycles remaining in the current phase as a countdown.
    bit [3:0] m_pend;
    int       m_floor;
    bit       m_dir;
    int       m_phase;
    int       m_left;

    bit [10:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    bit driver_done = 1'b0;

    function automatic bit any_ahead(input bit [3:0] p, input int f, input bit up);
        int lower_mask;
        lower_mask = (1 << f) - 1;
        if (up) return (p >> (f + 1)) != 4'b0000;
        return (int'(p) & lower_mask) != 0;
    endfunction

    task automatic model_step(input bit rst, input bit [2:0] hu, input bit [2:0] hd,
                              input bit [3:0] cc);
        bit [3:0] req;
        bit [3:0] add;
        if (rst) begin
            m_pend = 4'b0000; m_floor = 0; m_dir = 1'b1; m_phase = PH_IDLE; m_left = 0;
            return;
        end
        req = cc | {1'b0, hu} | {hd, 1'b0};
        add = req;
        case (m_phase)
            PH_IDLE: begin
                if (m_pend[m_floor]) begin
                    m_phase = PH_DOOR; m_left = DOOR_T;
                    m_pend[m_floor] = 1'b0; add[m_floor] = 1'b0;
                end else if (any_ahead(m_pend, m_floor, m_dir)) begin
                    m_phase = PH_MOVE; m_left = MOVE_T;
                end else if (any_ahead(m_pend, m_floor, !m_dir)) begin
                    m_dir = !m_dir; m_phase = PH_MOVE; m_left = MOVE_T;
                end
            end
            PH_MOVE: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_floor = m_floor + (m_dir ? 1 : -1);
                    if (m_pend[m_floor]) begin
                        m_phase = PH_DOOR; m_left = DOOR_T;
                        m_pend[m_floor] = 1'b0; add[m_floor] = 1'b0;
                    end else if (any_ahead(m_pend, m_floor, m_dir)) begin
                        m_left = MOVE_T;
                    end else begin
                        m_phase = PH_IDLE;
                    end
                end
            end
            default: begin
                if (req[m_floor]) begin
                    m_left = DOOR_T; add[m_floor] = 1'b0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = PH_IDLE;
                end
            end
        endcase
        m_pend = m_pend | add;
    endtask

    function automatic bit [10:0] model_outputs();
        bit [1:0] fl;
        fl = m_floor[1:0];
        return {fl, (m_phase == PH_MOVE) && m_dir, (m_phase == PH_MOVE) && !m_dir,
                m_phase == PH_DOOR, m_dir, m_pend, m_phase != PH_IDLE};
    endfunction

    task automatic cycle(input bit rst, input bit [2:0] hu, input bit [2:0] hd,
                         input bit [3:0] cc);
        @(negedge clk);
        reset = rst; hall_up = hu; hall_down = hd; car_call = cc;
        model_step(rst, hu, hd, cc);
        exp_q.push_back(model_outputs());
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'b000, 3'b000, 4'b0000);
    endtask

    // Monitor: pops one expected snapshot per clock edge and compares.
    initial begin
        bit [10:0] exp_v;
        bit [10:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {actualFloor, motor_up, motor_down, door_open, dir_up, pending, busy};
                n_checks++;
                if (act_v === exp_v) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs @%0t: got floor=%0d mu=%b md=%b door=%b dir=%b pend=%b busy=%b, want floor=%0d mu=%b md=%b door=%b dir=%b pend=%b busy=%b",
                             $time, act_v[10:9], act_v[8], act_v[7], act_v[6], act_v[5],
                             act_v[4:1], act_v[0], exp_v[10:9], exp_v[8], exp_v[7], exp_v[6],
                             exp_v[5], exp_v[4:1], exp_v[0]);
                end
            end
        end
    end

    initial begin
        int r;
        int b;
        bit [9:0] bits;
        bit rst;
        cycle(1'b1, 3'b000, 3'b000, 4'b0000);
        cycle(1'b1, 3'b000, 3'b000, 4'b0000);
        // Single cabin call from idle at floor 0.
        cycle(1'b0, 3'b000, 3'b000, 4'b0010);
        quiet(14);
        // Calls 1,2,3 in sequence after returning toward 0 via a car call.
        cycle(1'b0, 3'b000, 3'b000, 4'b0001);
        quiet(14);
        cycle(1'b0, 3'b000, 3'b000, 4'b0010);
        cycle(1'b0, 3'b000, 3'b000, 4'b0100);
        cycle(1'b0, 3'b000, 3'b000, 4'b1000);
        quiet(8);
        cycle(1'b0, 3'b000, 3'b000, 4'b0001);
        quiet(50);
        // Hall up at the current floor while idle: door without motion.
        cycle(1'b0, 3'b001, 3'b000, 4'b0000);
        quiet(8);
        // Reset mid-move.
        cycle(1'b0, 3'b000, 3'b000, 4'b1000);
        quiet(10);
        cycle(1'b1, 3'b000, 3'b000, 4'b0000);
        quiet(3);
        for (int c = 0; c < 4000; c++) begin
            r = $urandom_range(0, 99);
            bits = '0;
            if (r < 10) begin
                b = $urandom_range(0, 9);
                bits[b] = 1'b1;
                if (r < 2) begin
                    b = $urandom_range(0, 9);
                    bits[b] = 1'b1;
                end
            end
            rst = ($urandom_range(0, 599) == 0);
            cycle(rst, bits[2:0], bits[5:3], bits[9:6]);
        end
        quiet(2);
        driver_done = 1'b1;
    end

    initial begin
        int budget;
        wait (driver_done);
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d snapshots left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
